pb_debounce_array: RTL and testbench

Parametrised N-channel push-button/switch conditioner that replaces the single-channel synchroniser-plus-edge-detector used on the Basys3 board. Each channel has a multi-stage synchroniser, a counter-based stability filter that rejects contact bounce, and a debounced level output. Each channel also produces one-cycle press and release pulses and an optional hold-to-repeat pulse. The block sits between the board pins (buttons, switches) and the CPU's memory-mapped input logic.

---
 rtl/pb_debounce_array.sv | 189 ++++++++++++++++++
 tb/tb_pb_debounce_array.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/pb_debounce_array.sv
// -----------------------------------------------------------------------------
// pb_debounce_array
//
// N-channel push-button / switch conditioner. Every channel is independent:
//   raw pin -> SYNC_STAGES-deep synchroniser -> stability counter -> pb_level,
// plus registered one-cycle press/release pulses and an optional
// hold-to-repeat pulse.
//
// Optional feature macro: PB_DEBOUNCE_REPEAT_EN
//   defined   : per-channel IDLE/HOLD/REPEAT machine drives pb_repeat
//   undefined : no repeat logic is built, pb_repeat is tied to 0
//
// Ports
//   clk        system clock, all logic on its rising edge
//   rst_n      asynchronous active-low reset
//   pb_in      [N-1:0] raw asynchronous pin inputs, active high
//   pb_level   [N-1:0] debounced level
//   pb_down    [N-1:0] one-cycle pulse, coincident with pb_level rising
//   pb_up      [N-1:0] one-cycle pulse, coincident with pb_level falling
//   pb_repeat  [N-1:0] one-cycle auto-repeat pulse while a press is held
// -----------------------------------------------------------------------------
module pb_debounce_array #(
    parameter int N             = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 1000000,
    parameter int HOLD_CYCLES   = 50000000,
    parameter int REPEAT_CYCLES = 10000000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] pb_in,
    output logic [N-1:0] pb_level,
    output logic [N-1:0] pb_down,
    output logic [N-1:0] pb_up,
    output logic [N-1:0] pb_repeat
);

    // Illegal parameter sets elaborate to an inert block with all outputs low.
    localparam bit CFG_OK = (N >= 1) && (SYNC_STAGES >= 2) && (STABLE_CYCLES >= 1) &&
                            (HOLD_CYCLES >= 1) && (REPEAT_CYCLES >= 1);

    localparam int              CNT_W       = $clog2(STABLE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);

`ifdef PB_DEBOUNCE_REPEAT_EN
    // One counter serves both the initial hold delay and the repeat period.
    localparam int HOLD_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int HOLD_W   = $clog2(HOLD_MAX) + 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [HOLD_W-1:0] REPEAT_LAST = HOLD_W'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_REPEAT = 2'd2
    } rpt_state_e;
`endif

    if (CFG_OK) begin : g_cfg
        for (genvar i = 0; i < N; i++) begin : g_chan

            // ---------------- synchroniser + stability filter ----------------
            logic [SYNC_STAGES-1:0] sync_q, sync_d;
            logic [CNT_W-1:0]       cnt_q,  cnt_d;
            logic                   level_q, level_d;
            logic                   down_q,  down_d;
            logic                   up_q,    up_d;

            // NOTE: every signal assigned in an always_comb gets a default at
            // the top of the block, so no path can leave it unassigned and
            // infer a latch.
            always_comb begin
                sync_d  = {sync_q[SYNC_STAGES-2:0], pb_in[i]};
                cnt_d   = cnt_q;
                level_d = level_q;
                down_d  = 1'b0;
                up_d    = 1'b0;

                if (sync_q[SYNC_STAGES-1] == level_q) begin
                    // Agreement (including the end of any bounce) restarts the count.
                    cnt_d = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    level_d = ~level_q;
                    cnt_d   = '0;
                    // Pulses are registered alongside level so they line up with it.
                    down_d  = ~level_q;
                    up_d    =  level_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            // NOTE: sequential state uses non-blocking assignments only, so all
            // flops sample their _d values from before this clock edge.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync_q  <= '0;
                    cnt_q   <= '0;
                    level_q <= 1'b0;
                    down_q  <= 1'b0;
                    up_q    <= 1'b0;
                end else begin
                    sync_q  <= sync_d;
                    cnt_q   <= cnt_d;
                    level_q <= level_d;
                    down_q  <= down_d;
                    up_q    <= up_d;
                end
            end

            assign pb_level[i] = level_q;
            assign pb_down[i]  = down_q;
            assign pb_up[i]    = up_q;

`ifdef PB_DEBOUNCE_REPEAT_EN
            // ---------------- hold / repeat state machine ----------------
            // Driven from the same-edge level change (down_d/up_d) so the HOLD
            // count starts on the cycle pb_down is visible.
            rpt_state_e        state_q, state_d;
            logic [HOLD_W-1:0] hcnt_q,  hcnt_d;
            logic              rpt_q,   rpt_d;

            always_comb begin
                state_d = state_q;
                hcnt_d  = hcnt_q;
                rpt_d   = 1'b0;

                if (up_d) begin
                    // Release wins over a pulse that would land on the same edge.
                    state_d = ST_IDLE;
                    hcnt_d  = '0;
                end else begin
                    unique case (state_q)
                        ST_IDLE: begin
                            if (down_d) begin
                                state_d = ST_HOLD;
                                hcnt_d  = '0;
                            end
                        end
                        ST_HOLD: begin
                            if (hcnt_q == HOLD_LAST) begin
                                state_d = ST_REPEAT;
                                hcnt_d  = '0;
                                rpt_d   = 1'b1;
                            end else begin
                                hcnt_d = hcnt_q + HOLD_W'(1);
                            end
                        end
                        ST_REPEAT: begin
                            if (hcnt_q == REPEAT_LAST) begin
                                hcnt_d = '0;
                                rpt_d  = 1'b1;
                            end else begin
                                hcnt_d = hcnt_q + HOLD_W'(1);
                            end
                        end
                        default: begin
                            state_d = ST_IDLE;
                            hcnt_d  = '0;
                        end
                    endcase
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    state_q <= ST_IDLE;
                    hcnt_q  <= '0;
                    rpt_q   <= 1'b0;
                end else begin
                    state_q <= state_d;
                    hcnt_q  <= hcnt_d;
                    rpt_q   <= rpt_d;
                end
            end

            assign pb_repeat[i] = rpt_q;
`else
            assign pb_repeat[i] = 1'b0;
`endif
        end
    end else begin : g_cfg_bad
        assign pb_level  = '0;
        assign pb_down   = '0;
        assign pb_up     = '0;
        assign pb_repeat = '0;
    end

endmodule

// File: tb/tb_pb_debounce_array.sv
// -----------------------------------------------------------------------------
// tb_pb_debounce_array
//
// Self-checking bench for pb_debounce_array (N=4, SYNC_STAGES=2,
// STABLE_CYCLES=4, HOLD_CYCLES=10, REPEAT_CYCLES=3).
// Stimulus changes on the falling edge; when an input is made stable, the
// expected pulse cycles are derived from the latency rules and pushed to a
// scoreboard queue. A falling-edge monitor pops the entries due on the current
// cycle and compares level/down/up/repeat every cycle, so stray pulses are
// caught as well as missing ones. Repeat expectations follow
// PB_DEBOUNCE_REPEAT_EN.
// -----------------------------------------------------------------------------
module tb_pb_debounce_array;

    localparam int N      = 4;
    localparam int SYNC   = 2;
    localparam int STABLE = 4;
    localparam int HOLD   = 10;
    localparam int REP    = 3;
    // Drive on the falling edge before edge k; the new level shows after edge k+SYNC+STABLE-1.
    localparam int LAT    = 1 + SYNC + STABLE - 1;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] pb_in;
    logic [N-1:0] pb_level, pb_down, pb_up, pb_repeat;

    pb_debounce_array #(
        .N             (N),
        .SYNC_STAGES   (SYNC),
        .STABLE_CYCLES (STABLE),
        .HOLD_CYCLES   (HOLD),
        .REPEAT_CYCLES (REP)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pb_in     (pb_in),
        .pb_level  (pb_level),
        .pb_down   (pb_down),
        .pb_up     (pb_up),
        .pb_repeat (pb_repeat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    // ---------------- scoreboard ----------------
    typedef struct {
        int           t;
        logic [N-1:0] dn;
        logic [N-1:0] up;
        logic [N-1:0] rp;
    } exp_t;

    exp_t exp_q[$];

    task automatic push_exp(input int t, input logic [N-1:0] dn, input logic [N-1:0] up,
                            input logic [N-1:0] rp);
        exp_t e;
        e.t  = t;
        e.dn = dn;
        e.up = up;
        e.rp = rp;
        exp_q.push_back(e);
    endtask

    // Repeat pulses for a press whose pb_down is at cycle d and pb_up at cycle u.
    task automatic push_repeats(input int ch, input int d, input int u);
`ifdef PB_DEBOUNCE_REPEAT_EN
        for (int t = d + HOLD; t < u; t += REP) push_exp(t, '0, '0, N'(1 << ch));
`else
        if (ch < 0 || d > u) $display("note: odd repeat window ch=%0d d=%0d u=%0d", ch, d, u);
`endif
    endtask

    logic [N-1:0] exp_level = '0;
    logic [N-1:0] e_dn, e_up, e_rp;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_level = '0;
            exp_q.delete();
        end else begin
            e_dn = '0;
            e_up = '0;
            e_rp = '0;
            for (int i = exp_q.size() - 1; i >= 0; i--) begin
                if (exp_q[i].t == cyc) begin
                    e_dn |= exp_q[i].dn;
                    e_up |= exp_q[i].up;
                    e_rp |= exp_q[i].rp;
                    exp_q.delete(i);
                end
            end
            exp_level = (exp_level | e_dn) & ~e_up;
            check("level",  32'(pb_level),  32'(exp_level));
            check("down",   32'(pb_down),   32'(e_dn));
            check("up",     32'(pb_up),     32'(e_up));
            check("repeat", 32'(pb_repeat), 32'(e_rp));
        end
    end

    // ---------------- helpers ----------------
    task automatic wait_to(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_level"},  32'(pb_level),  32'h0);
        check({tag, "_down"},   32'(pb_down),   32'h0);
        check({tag, "_up"},     32'(pb_up),     32'h0);
        check({tag, "_repeat"}, 32'(pb_repeat), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    int d, u, c;
    int pat[7] = '{1, 1, 0, 1, 1, 1, 0};

    initial begin
        rst_n = 1'b1;
        pb_in = '1;

        // Reset values: asynchronous clear before any clock edge.
        #1 rst_n = 1'b0;
        #1 check_all_zero("rst_async");

        // Release with all inputs held high: normal press after full latency.
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        d = cyc + LAT;
        push_exp(d, '1, '0, '0);
        wait_to(d + 1);
        pb_in = '0;
        u = cyc + LAT;
        push_exp(u, '0, '1, '0);
        for (int ch = 0; ch < N; ch++) push_repeats(ch, d, u);
        wait_to(u + 3);

        // Clean press and release on channel 0.
        pb_in[0] = 1'b1;
        d = cyc + LAT;
        push_exp(d, 4'b0001, '0, '0);
        wait_to(d + 2);
        pb_in[0] = 1'b0;
        u = cyc + LAT;
        push_exp(u, '0, 4'b0001, '0);
        push_repeats(0, d, u);
        wait_to(u + 3);

        // Bounce on channel 1: 1,1,0,1,1,1,0 then steady 1.
        for (int j = 0; j < 7; j++) begin
            pb_in[1] = 1'(pat[j]);
            @(negedge clk);
        end
        pb_in[1] = 1'b1;
        d = cyc + LAT;
        push_exp(d, 4'b0010, '0, '0);
        wait_to(d + 1);
        pb_in[1] = 1'b0;
        u = cyc + LAT;
        push_exp(u, '0, 4'b0010, '0);
        push_repeats(1, d, u);
        wait_to(u + 3);

        // Hold/repeat on channel 2; release lands where a pulse would be due.
        pb_in[2] = 1'b1;
        d = cyc + LAT;
        u = d + 31;
        push_exp(d, 4'b0100, '0, '0);
        push_repeats(2, d, u);
        wait_to(u - LAT);
        pb_in[2] = 1'b0;
        push_exp(u, '0, 4'b0100, '0);
        wait_to(u + 6);

        // Simultaneous press on channel 0 and release on channel 3.
        pb_in[3] = 1'b1;
        d = cyc + LAT;
        push_exp(d, 4'b1000, '0, '0);
        wait_to(d + 1);
        c = cyc;
        pb_in[0] = 1'b1;
        pb_in[3] = 1'b0;
        push_exp(c + LAT, 4'b0001, 4'b1000, '0);
        push_repeats(3, d, c + LAT);
        wait_to(c + 7);
        pb_in[0] = 1'b0;
        u = cyc + LAT;
        push_exp(u, '0, 4'b0001, '0);
        push_repeats(0, c + LAT, u);
        wait_to(u + 3);

        // Reset during channel 2's repeat phase, input held across reset.
        pb_in[2] = 1'b1;
        d = cyc + LAT;
        push_exp(d, 4'b0100, '0, '0);
        push_repeats(2, d, d + 14);
        wait_to(d + 14);
        #2 rst_n = 1'b0;
        #1 check_all_zero("rst_mid");
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        d = cyc + LAT;
        push_exp(d, 4'b0100, '0, '0);
        wait_to(d + 1);
        pb_in[2] = 1'b0;
        u = cyc + LAT;
        push_exp(u, '0, 4'b0100, '0);
        push_repeats(2, d, u);
        wait_to(u + 4);

        check("sb_empty", 32'(exp_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
